// File: rtl/mxv_cmd_loader.sv
`default_nettype none
// ============================================================================
// Module : mxv_cmd_loader
// Desc   : UART command-frame parser; programs N, streams matrix writes,
//          assembles the vector register and issues processor start.
// Rev    : 1.0 - initial release
// ============================================================================
module mxv_cmd_loader #(
  parameter int                DATA_W = 8,
  parameter int                MAX_N  = 8,
  parameter int                IDX_W  = $clog2(MAX_N),
  parameter logic [DATA_W-1:0] SOF    = 8'hFE,
  parameter logic [DATA_W-1:0] EOF    = 8'hEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       rx_data,
  input  logic                    rx_valid,
  input  logic                    proc_busy,
  output logic                    mat_we,
  output logic [IDX_W-1:0]        mat_row,
  output logic [IDX_W-1:0]        mat_col,
  output logic [DATA_W-1:0]       mat_wdata,
  output logic [MAX_N*DATA_W-1:0] vec_o,
  output logic [IDX_W:0]          size_o,
  output logic                    mat_valid,
  output logic                    vec_valid,
  output logic                    start_o,
  output logic                    frame_ok,
  output logic                    frame_err,
  output logic [2:0]              err_code
);

  localparam int c_SZ_W  = IDX_W + 1;
  // Wide enough for N*N+1 and for a zero-extended received byte.
  localparam int c_EXP_W = (2*c_SZ_W + 1 > DATA_W + 1) ? 2*c_SZ_W + 1 : DATA_W + 1;

  localparam logic [DATA_W-1:0] c_CMD_SET_SIZE = DATA_W'(8'h01);
  localparam logic [DATA_W-1:0] c_CMD_START    = DATA_W'(8'h03);
  localparam logic [DATA_W-1:0] c_CMD_LOAD_MAT = DATA_W'(8'h04);
  localparam logic [DATA_W-1:0] c_CMD_LOAD_VEC = DATA_W'(8'h05);

  localparam logic [2:0] c_ERR_LEN0    = 3'd1;
  localparam logic [2:0] c_ERR_CMD     = 3'd2;
  localparam logic [2:0] c_ERR_SIZE    = 3'd3;
  localparam logic [2:0] c_ERR_LEN     = 3'd4;
  localparam logic [2:0] c_ERR_START   = 3'd5;
  localparam logic [2:0] c_ERR_TRAILER = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_CMD     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_TRAIL   = 3'd4
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [DATA_W-1:0]         r_len, r_cmd, r_rem;
  logic [IDX_W-1:0]          r_row, r_col, r_idx;
  logic [c_SZ_W-1:0]         r_size, r_size_sh;
  logic [MAX_N*DATA_W-1:0]   r_vec, r_vec_sh;
  logic                      r_mat_we, r_mat_valid, r_vec_valid;
  logic [IDX_W-1:0]          r_mat_row, r_mat_col;
  logic [DATA_W-1:0]         r_mat_wdata;
  logic                      r_start, r_frame_ok, r_frame_err;
  logic [2:0]                r_err_code;

  logic                      w_ok, w_err, w_start, w_cmd_known, w_size_bad, w_start_ready;
  logic [2:0]                w_code;
  logic [c_EXP_W-1:0]        w_exp_len;

  always_comb begin
    w_cmd_known = 1'b1;
    w_exp_len   = '0;
    case (rx_data)
      c_CMD_SET_SIZE: w_exp_len = c_EXP_W'(2);
      c_CMD_START:    w_exp_len = c_EXP_W'(1);
      c_CMD_LOAD_MAT: w_exp_len = c_EXP_W'(r_size) * c_EXP_W'(r_size) + c_EXP_W'(1);
      c_CMD_LOAD_VEC: w_exp_len = c_EXP_W'(r_size) + c_EXP_W'(1);
      default:        w_cmd_known = 1'b0;
    endcase
  end

  assign w_size_bad    = (rx_data == '0) || (c_EXP_W'(rx_data) > c_EXP_W'(MAX_N));
  assign w_start_ready = r_mat_valid && r_vec_valid && !proc_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ok        = 1'b0;
    w_err       = 1'b0;
    w_start     = 1'b0;
    w_code      = '0;
    if (rx_valid) begin
      case (r_state)
        S_IDLE: begin
          if (rx_data == SOF) w_state_nxt = S_LEN;
        end
        S_LEN: begin
          if (rx_data == '0) begin
            w_err       = 1'b1;
            w_code      = c_ERR_LEN0;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_CMD;
          end
        end
        S_CMD: begin
          if (!w_cmd_known) begin
            w_err       = 1'b1;
            w_code      = c_ERR_CMD;
            w_state_nxt = S_IDLE;
          end else if (c_EXP_W'(r_len) != w_exp_len) begin
            w_err       = 1'b1;
            w_code      = c_ERR_LEN;
            w_state_nxt = S_IDLE;
          end else if (r_len == DATA_W'(1)) begin
            w_state_nxt = S_TRAIL;
          end else begin
            w_state_nxt = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (r_cmd == c_CMD_SET_SIZE && w_size_bad) begin
            w_err       = 1'b1;
            w_code      = c_ERR_SIZE;
            w_state_nxt = S_IDLE;
          end else if (r_rem == DATA_W'(1)) begin
            w_state_nxt = S_TRAIL;
          end
        end
        S_TRAIL: begin
          w_state_nxt = S_IDLE;
          if (rx_data != EOF) begin
            w_err  = 1'b1;
            w_code = c_ERR_TRAILER;
          end else if (r_cmd == c_CMD_START) begin
            // A successful START reports through start_o alone so the pulses stay exclusive.
            if (w_start_ready) begin
              w_start = 1'b1;
            end else begin
              w_err  = 1'b1;
              w_code = c_ERR_START;
            end
          end else begin
            w_ok = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len       <= '0;
      r_cmd       <= '0;
      r_rem       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_idx       <= '0;
      r_size      <= c_SZ_W'(MAX_N);
      r_size_sh   <= '0;
      r_vec       <= '0;
      r_vec_sh    <= '0;
      r_mat_we    <= 1'b0;
      r_mat_row   <= '0;
      r_mat_col   <= '0;
      r_mat_wdata <= '0;
      r_mat_valid <= 1'b0;
      r_vec_valid <= 1'b0;
      r_start     <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_mat_we    <= 1'b0;
      r_frame_ok  <= w_ok;
      r_frame_err <= w_err;
      r_start     <= w_start;
      if (w_err) r_err_code <= w_code;
      if (rx_valid) begin
        case (r_state)
          S_LEN: r_len <= rx_data;
          S_CMD: begin
            r_cmd <= rx_data;
            r_rem <= r_len - DATA_W'(1);
            r_row <= '0;
            r_col <= '0;
            r_idx <= '0;
            if (!w_err) begin
              if (rx_data == c_CMD_LOAD_MAT) r_mat_valid <= 1'b0;
              // Seeding the shadow keeps elements beyond N unchanged on commit.
              if (rx_data == c_CMD_LOAD_VEC) r_vec_sh <= r_vec;
            end
          end
          S_PAYLOAD: begin
            r_rem <= r_rem - DATA_W'(1);
            case (r_cmd)
              c_CMD_SET_SIZE: r_size_sh <= rx_data[IDX_W:0];
              c_CMD_LOAD_MAT: begin
                r_mat_we    <= 1'b1;
                r_mat_row   <= r_row;
                r_mat_col   <= r_col;
                r_mat_wdata <= rx_data;
                if ({1'b0, r_col} == r_size - c_SZ_W'(1)) begin
                  r_col <= '0;
                  r_row <= r_row + IDX_W'(1);
                end else begin
                  r_col <= r_col + IDX_W'(1);
                end
              end
              c_CMD_LOAD_VEC: begin
                r_vec_sh[r_idx*DATA_W +: DATA_W] <= rx_data;
                r_idx <= r_idx + IDX_W'(1);
              end
              default: ;
            endcase
          end
          S_TRAIL: begin
            if (w_ok) begin
              case (r_cmd)
                c_CMD_SET_SIZE: begin
                  r_size      <= r_size_sh;
                  r_mat_valid <= 1'b0;
                  r_vec_valid <= 1'b0;
                end
                c_CMD_LOAD_MAT: r_mat_valid <= 1'b1;
                c_CMD_LOAD_VEC: begin
                  r_vec       <= r_vec_sh;
                  r_vec_valid <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mat_we    = r_mat_we;
  assign mat_row   = r_mat_row;
  assign mat_col   = r_mat_col;
  assign mat_wdata = r_mat_wdata;
  assign vec_o     = r_vec;
  assign size_o    = r_size;
  assign mat_valid = r_mat_valid;
  assign vec_valid = r_vec_valid;
  assign start_o   = r_start;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_mxv_cmd_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_mxv_cmd_loader
// Desc   : Directed and randomized frame checks against a frame-level model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mxv_cmd_loader;

  localparam int DATA_W = 8;
  localparam int MAX_N  = 8;
  localparam int IDX_W  = 3;
  localparam logic [7:0] SOF = 8'hFE;
  localparam logic [7:0] EOF = 8'hEF;

  typedef logic [7:0] bq_t[$];
  typedef logic [2*IDX_W+7:0] wr_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [DATA_W-1:0]       rx_data;
  logic                    rx_valid;
  logic                    proc_busy;
  logic                    mat_we;
  logic [IDX_W-1:0]        mat_row, mat_col;
  logic [DATA_W-1:0]       mat_wdata;
  logic [MAX_N*DATA_W-1:0] vec_o;
  logic [IDX_W:0]          size_o;
  logic                    mat_valid, vec_valid, start_o, frame_ok, frame_err;
  logic [2:0]              err_code;

  int n_chk = 0, n_pass = 0;
  int n_ok, n_err, n_start, n_multi = 0;
  wr_t wq[$];

  // frame-level model state
  int   m_size;
  bit   m_mv, m_vv;
  logic [7:0] m_vec[MAX_N];
  logic [2:0] m_code;
  int   e_ok, e_err, e_start;
  wr_t  e_wq[$];

  mxv_cmd_loader #(.DATA_W(DATA_W), .MAX_N(MAX_N), .IDX_W(IDX_W), .SOF(SOF), .EOF(EOF)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .proc_busy(proc_busy),
    .mat_we(mat_we), .mat_row(mat_row), .mat_col(mat_col), .mat_wdata(mat_wdata),
    .vec_o(vec_o), .size_o(size_o), .mat_valid(mat_valid), .vec_valid(vec_valid),
    .start_o(start_o), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_ok)  n_ok++;
    if (frame_err) n_err++;
    if (start_o)   n_start++;
    if (int'(frame_ok) + int'(frame_err) + int'(start_o) > 1) n_multi++;
    if (mat_we) wq.push_back({mat_row, mat_col, mat_wdata});
  end

  task automatic clear_mon;
    n_ok = 0; n_err = 0; n_start = 0; wq.delete();
  endtask

  task automatic apply_reset;
    rst = 1'b1; rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(input bq_t f, input bit gaps);
    foreach (f[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(negedge clk); rx_valid = 1'b0; end
      @(negedge clk); rx_data = f[i]; rx_valid = 1'b1;
    end
    @(negedge clk); rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; proc_busy = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (size_o !== 4'd8) $display("FAIL reset.size got %0d exp 8", size_o); else n_pass++;
    n_chk++; if ({mat_we, mat_valid, vec_valid, start_o, frame_ok, frame_err} !== 6'b0)
      $display("FAIL reset.flags got %b exp 000000", {mat_we, mat_valid, vec_valid, start_o, frame_ok, frame_err}); else n_pass++;
    n_chk++; if (vec_o !== '0 || err_code !== 3'd0 || mat_row !== '0 || mat_col !== '0 || mat_wdata !== '0)
      $display("FAIL reset.data got vec %h code %0d exp 0", vec_o, err_code); else n_pass++;
    rst = 1'b0;
    clear_mon;
  endtask

  task automatic test_set_size;
    bq_t f;
    f = {8'hFE, 8'h02, 8'h01, 8'h03, 8'hEF};
    clear_mon; send_frame(f, 1'b0);
    n_chk++; if (size_o !== 4'd3) $display("FAIL set_size.size got %0d exp 3", size_o); else n_pass++;
    n_chk++; if (n_ok !== 1 || n_err !== 0) $display("FAIL set_size.pulses got ok %0d err %0d exp 1 0", n_ok, n_err); else n_pass++;
    n_chk++; if (mat_valid !== 1'b0 || vec_valid !== 1'b0) $display("FAIL set_size.valid got %b%b exp 00", mat_valid, vec_valid); else n_pass++;
  endtask

  task automatic test_load_mat;
    bq_t f;
    wr_t exp_w[4], got;
    exp_w[0] = {3'd0, 3'd0, 8'h01}; exp_w[1] = {3'd0, 3'd1, 8'h02};
    exp_w[2] = {3'd1, 3'd0, 8'h03}; exp_w[3] = {3'd1, 3'd1, 8'h04};
    f = {8'hFE, 8'h02, 8'h01, 8'h02, 8'hEF};
    send_frame(f, 1'b0);
    f = {8'hFE, 8'h05, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hEF};
    clear_mon; send_frame(f, 1'b0);
    n_chk++; if (wq.size() !== 4) $display("FAIL load_mat.count got %0d exp 4", wq.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      got = (i < wq.size()) ? wq[i] : 'x;
      n_chk++; if (got !== exp_w[i]) $display("FAIL load_mat.write%0d got %h exp %h", i, got, exp_w[i]); else n_pass++;
    end
    n_chk++; if (mat_valid !== 1'b1 || n_ok !== 1) $display("FAIL load_mat.valid got mv %b ok %0d exp 1 1", mat_valid, n_ok); else n_pass++;
  endtask

  task automatic test_load_vec_start;
    bq_t f;
    f = {8'hFE, 8'h03, 8'h05, 8'h05, 8'h06, 8'hEF};
    clear_mon; send_frame(f, 1'b1);
    n_chk++; if (vec_o[15:0] !== 16'h0605 || vec_valid !== 1'b1)
      $display("FAIL load_vec.vec got %h vv %b exp 0605 1", vec_o[15:0], vec_valid); else n_pass++;
    proc_busy = 1'b0;
    f = {8'hFE, 8'h01, 8'h03, 8'hEF};
    clear_mon; send_frame(f, 1'b0);
    n_chk++; if (n_start !== 1 || n_ok !== 0 || n_err !== 0)
      $display("FAIL start.idle got start %0d ok %0d err %0d exp 1 0 0", n_start, n_ok, n_err); else n_pass++;
    proc_busy = 1'b1;
    clear_mon; send_frame(f, 1'b0);
    n_chk++; if (n_start !== 0 || n_err !== 1 || err_code !== 3'd5)
      $display("FAIL start.busy got start %0d err %0d code %0d exp 0 1 5", n_start, n_err, err_code); else n_pass++;
    proc_busy = 1'b0;
  endtask

  task automatic test_len_mismatch;
    bq_t f;
    f = {8'hFE, 8'h04, 8'h05};
    clear_mon; send_frame(f, 1'b0);
    n_chk++; if (n_err !== 1 || err_code !== 3'd4 || vec_o[15:0] !== 16'h0605)
      $display("FAIL len_mismatch got err %0d code %0d vec %h exp 1 4 0605", n_err, err_code, vec_o[15:0]); else n_pass++;
    f = {8'hFE, 8'h03, 8'h05, 8'h07, 8'h08, 8'hEF};
    clear_mon; send_frame(f, 1'b0);
    n_chk++; if (n_ok !== 1 || vec_o[15:0] !== 16'h0807)
      $display("FAIL len_recover got ok %0d vec %h exp 1 0807", n_ok, vec_o[15:0]); else n_pass++;
  endtask

  task automatic test_bad_frames;
    bq_t f;
    f = {8'hFE, 8'h02, 8'h01, 8'h09, 8'hEF};
    clear_mon; send_frame(f, 1'b0);
    n_chk++; if (err_code !== 3'd3 || size_o !== 4'd2 || n_err !== 1 || n_ok !== 0)
      $display("FAIL bad_size got code %0d size %0d err %0d exp 3 2 1", err_code, size_o, n_err); else n_pass++;
    f = {8'hFE, 8'h02, 8'h01, 8'h02, 8'hAA};
    clear_mon; send_frame(f, 1'b0);
    n_chk++; if (err_code !== 3'd6 || size_o !== 4'd2 || n_err !== 1)
      $display("FAIL bad_trailer got code %0d size %0d err %0d exp 6 2 1", err_code, size_o, n_err); else n_pass++;
    f = {8'hFE, 8'h01, 8'h07};
    clear_mon; send_frame(f, 1'b0);
    n_chk++; if (err_code !== 3'd2 || n_err !== 1) $display("FAIL bad_cmd got code %0d err %0d exp 2 1", err_code, n_err); else n_pass++;
    f = {8'hFE, 8'h00};
    clear_mon; send_frame(f, 1'b0);
    n_chk++; if (err_code !== 3'd1 || n_err !== 1) $display("FAIL len_zero got code %0d err %0d exp 1 1", err_code, n_err); else n_pass++;
    f = {8'h33, 8'hFE, 8'h03, 8'h05, 8'hFE, 8'hFE, 8'hEF};
    clear_mon; send_frame(f, 1'b0);
    n_chk++; if (n_ok !== 1 || vec_o[15:0] !== 16'hFEFE)
      $display("FAIL sof_in_payload got ok %0d vec %h exp 1 fefe", n_ok, vec_o[15:0]); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    bq_t f;
    f = {8'hFE, 8'h05, 8'h04, 8'h11, 8'h22, 8'h33};
    clear_mon;
    foreach (f[i]) begin @(negedge clk); rx_data = f[i]; rx_valid = 1'b1; end
    #1 rst = 1'b1;
    #1;
    n_chk++; if (size_o !== 4'd8 || err_code !== 3'd0 || vec_o !== '0)
      $display("FAIL mid_reset.data got size %0d code %0d vec %h exp 8 0 0", size_o, err_code, vec_o); else n_pass++;
    n_chk++; if ({mat_we, mat_valid, vec_valid, start_o, frame_ok, frame_err} !== 6'b0)
      $display("FAIL mid_reset.flags got %b exp 000000", {mat_we, mat_valid, vec_valid, start_o, frame_ok, frame_err}); else n_pass++;
    @(negedge clk); rx_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    f = {8'hFE, 8'h02, 8'h01, 8'h04, 8'hEF};
    clear_mon; send_frame(f, 1'b0);
    n_chk++; if (size_o !== 4'd4 || n_ok !== 1) $display("FAIL mid_reset.reparse got size %0d ok %0d exp 4 1", size_o, n_ok); else n_pass++;
  endtask

  // Predicts the outcome of one frame from the command rules alone.
  task automatic model_frame(input bq_t f);
    int p, len, exp_len;
    logic [7:0] cmd;
    e_ok = 0; e_err = 0; e_start = 0; e_wq.delete();
    p = 0;
    while (f[p] != SOF) p++;
    len = int'(f[p+1]);
    if (len == 0) begin e_err = 1; m_code = 3'd1; return; end
    cmd = f[p+2];
    case (cmd)
      8'h01: exp_len = 2;
      8'h03: exp_len = 1;
      8'h04: exp_len = m_size * m_size + 1;
      8'h05: exp_len = m_size + 1;
      default: begin e_err = 1; m_code = 3'd2; return; end
    endcase
    if (len != exp_len) begin e_err = 1; m_code = 3'd4; return; end
    if (cmd == 8'h04) m_mv = 0;
    if (cmd == 8'h01 && (f[p+3] == 0 || int'(f[p+3]) > MAX_N)) begin e_err = 1; m_code = 3'd3; return; end
    if (cmd == 8'h04)
      for (int i = 0; i < len - 1; i++)
        e_wq.push_back({IDX_W'(i / m_size), IDX_W'(i % m_size), f[p+3+i]});
    if (f[p+2+len] != EOF) begin e_err = 1; m_code = 3'd6; return; end
    case (cmd)
      8'h01: begin m_size = int'(f[p+3]); m_mv = 0; m_vv = 0; e_ok = 1; end
      8'h03: if (m_mv && m_vv && !proc_busy) e_start = 1; else begin e_err = 1; m_code = 3'd5; end
      8'h04: begin m_mv = 1; e_ok = 1; end
      default: begin
        for (int i = 0; i < len - 1; i++) m_vec[i] = f[p+3+i];
        m_vv = 1; e_ok = 1;
      end
    endcase
  endtask

  task automatic test_random;
    bq_t f, pl;
    int q, kind, len;
    logic [7:0] cmd, x;
    logic [MAX_N*DATA_W-1:0] exp_vec;
    bit wbad;
    apply_reset;
    m_size = MAX_N; m_mv = 0; m_vv = 0; m_code = 3'd0;
    foreach (m_vec[i]) m_vec[i] = 8'h00;
    n_multi = 0;
    for (int t = 0; t < 80; t++) begin
      f = {}; pl = {};
      if ($urandom_range(0, 4) == 0) begin x = 8'($urandom_range(0, 8'hFD)); f.push_back(x); end
      q = f.size();
      case ($urandom_range(0, 3))
        0: begin
          cmd = 8'h01;
          x = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(1, MAX_N));
          pl.push_back(x);
        end
        1: begin cmd = 8'h04; repeat (m_size * m_size) pl.push_back(8'($urandom_range(0, 255))); end
        2: begin cmd = 8'h05; repeat (m_size) pl.push_back(8'($urandom_range(0, 255))); end
        default: cmd = 8'h03;
      endcase
      len = pl.size() + 1;
      f.push_back(SOF); f.push_back(8'(len)); f.push_back(cmd);
      foreach (pl[i]) f.push_back(pl[i]);
      f.push_back(EOF);
      kind = $urandom_range(0, 11);
      if (kind == 0) begin
        f[q+1] = 8'h00;
        while (f.size() > q + 2) void'(f.pop_back());
      end else if (kind == 1) begin
        f[q+2] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(6, 255));
        while (f.size() > q + 3) void'(f.pop_back());
      end else if (kind == 2) begin
        f[q+1] = 8'(len + 1);
        while (f.size() > q + 3) void'(f.pop_back());
      end else if (kind == 3) begin
        x = 8'($urandom_range(0, 255));
        if (x == EOF || x == SOF) x = 8'h00;
        f[f.size()-1] = x;
      end
      proc_busy = ($urandom_range(0, 3) == 0);
      model_frame(f);
      clear_mon; send_frame(f, 1'($urandom_range(0, 1)));
      for (int i = 0; i < MAX_N; i++) exp_vec[i*DATA_W +: DATA_W] = m_vec[i];
      wbad = (wq.size() != e_wq.size());
      if (!wbad) foreach (wq[i]) if (wq[i] !== e_wq[i]) wbad = 1;
      n_chk++; if (n_ok !== e_ok) $display("FAIL rnd%0d.frame_ok got %0d exp %0d", t, n_ok, e_ok); else n_pass++;
      n_chk++; if (n_err !== e_err) $display("FAIL rnd%0d.frame_err got %0d exp %0d", t, n_err, e_err); else n_pass++;
      n_chk++; if (n_start !== e_start) $display("FAIL rnd%0d.start got %0d exp %0d", t, n_start, e_start); else n_pass++;
      n_chk++; if (err_code !== m_code) $display("FAIL rnd%0d.err_code got %0d exp %0d", t, err_code, m_code); else n_pass++;
      n_chk++; if (int'(size_o) !== m_size) $display("FAIL rnd%0d.size got %0d exp %0d", t, size_o, m_size); else n_pass++;
      n_chk++; if (mat_valid !== m_mv || vec_valid !== m_vv)
        $display("FAIL rnd%0d.valid got %b%b exp %b%b", t, mat_valid, vec_valid, m_mv, m_vv); else n_pass++;
      n_chk++; if (vec_o !== exp_vec) $display("FAIL rnd%0d.vec got %h exp %h", t, vec_o, exp_vec); else n_pass++;
      n_chk++; if (wbad) $display("FAIL rnd%0d.writes got %0d exp %0d entries", t, wq.size(), e_wq.size()); else n_pass++;
    end
    proc_busy = 1'b0;
    n_chk++; if (n_multi !== 0) $display("FAIL exclusive_pulses got %0d overlaps exp 0", n_multi); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; proc_busy = 1'b0;
    test_reset;
    test_set_size;
    test_load_mat;
    test_load_vec_start;
    test_len_mismatch;
    test_bad_frames;
    test_reset_mid_frame;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mxv_cmd_loader.md
Name: mxv_cmd_loader

Overview:
- Parametrised command-frame loader for the matrix-vector (MxV) accelerator.
- Receives the UART byte stream, validates framed commands, and programs matrix size.
- Streams matrix elements to the bank-RAM write port and assembles the vector register.
- Issues an operation start to the processor; adds length checking, error reporting and load-state tracking that the fixed-size data feeder lacks.

Parameters:
DATA_W, 8, width of received words and matrix/vector elements
MAX_N, 8, maximum matrix dimension (N x N matrix, N-element vector)
IDX_W, $clog2(MAX_N), row/column index width
SOF, 8'hFE, start-of-frame byte
EOF, 8'hEF, end-of-frame byte

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
rx_data  in  DATA_W  received byte from UART receiver
rx_valid  in  1  one-cycle strobe, rx_data valid
proc_busy  in  1  processor operation in progress
mat_we  out  1  matrix element write strobe
mat_row  out  IDX_W  element row
mat_col  out  IDX_W  element column
mat_wdata  out  DATA_W  element value
vec_o  out  MAX_N*DATA_W  vector; element i at [i*DATA_W +: DATA_W]
size_o  out  IDX_W+1  programmed N
mat_valid  out  1  full matrix loaded for current N
vec_valid  out  1  full vector loaded for current N
start_o  out  1  one-cycle operation start pulse
frame_ok  out  1  one-cycle pulse on accepted frame
frame_err  out  1  one-cycle pulse on rejected frame
err_code  out  3  cause of last error, held until next error

Behaviour:
- Frame format: SOF, LEN, CMD, payload (LEN-1 bytes), EOF. LEN counts CMD plus payload.
- Only cycles with rx_valid=1 advance the FSM.
- Reset values: all outputs 0, except size_o = MAX_N.
- FSM states:
  - IDLE: wait for SOF; any other byte is ignored silently.
  - LEN: capture LEN. LEN=0 -> error 1, return to IDLE.
  - CMD: capture CMD; check LEN against the command's expected length.
  - PAYLOAD: count down remaining bytes.
  - TRAIL: expect EOF.
- Commands and expected LEN:
  - 0x01 SET_SIZE: LEN=2. Payload N must satisfy 1..MAX_N, else error 3. On commit: size_o=N, mat_valid and vec_valid cleared.
  - 0x04 LOAD_MAT: LEN=N*N+1. Payload is row-major. Each payload byte drives mat_we=1 for exactly one cycle, the cycle after its rx_valid, with mat_row/mat_col from internal counters. Column wraps at N-1 -> 0 and row increments.
  - 0x05 LOAD_VEC: LEN=N+1. Element i is written into a shadow register; vec_o updates from the shadow only at a valid EOF.
  - 0x03 START: LEN=1. At EOF, if mat_valid & vec_valid & !proc_busy -> start_o pulse, else error 5.
- Error codes (in order of detection):
  - Unknown CMD -> 2.
  - LEN mismatch -> 4, detected in CMD state, back to IDLE.
  - Bad trailer -> 6.
- Any error: frame_err pulse and return to IDLE. For LOAD_MAT, mat_valid stays 0 because matrix writes were already issued. For LOAD_VEC, vec_o is unchanged.
- On a valid EOF: frame_ok pulse. LOAD_MAT sets mat_valid; LOAD_VEC sets vec_valid.
- LOAD_MAT clears mat_valid when its CMD is accepted.
- A SOF byte inside a payload is treated as data; no resynchronisation until trailer check.
- rx_valid on consecutive cycles must be supported; there is no backpressure.
- frame_ok, frame_err and start_o are mutually exclusive in any cycle.
- Latency: frame_ok, frame_err and start_o assert the cycle after the EOF byte's rx_valid.
- Async reset mid-frame: return to IDLE immediately, restoring all outputs to their reset values.

Test Plan:
- SET_SIZE: FE,02,01,03,EF -> size_o=3, frame_ok=1 once, mat_valid=vec_valid=0.
- LOAD_MAT (N=2): FE,05,04,01,02,03,04,EF -> four mat_we pulses with (row,col,data) = (0,0,01), (0,1,02), (1,0,03), (1,1,04); then mat_valid=1.
- LOAD_VEC then START (N=2): FE,03,05,05,06,EF -> vec_o[15:0]=16'h0605, vec_valid=1. Then FE,01,03,EF with proc_busy=0 -> start_o one pulse. Repeat with proc_busy=1 -> frame_err, err_code=5, no start_o.
- LEN mismatch (N=2): FE,04,05,... -> frame_err, err_code=4, vec_o unchanged. Following valid frame FE,03,05,07,08,EF is accepted.
- Bad trailer and illegal size: FE,02,01,09,EF (N=9) -> err_code=3, size_o unchanged. FE,02,01,02,AA -> err_code=6, size_o unchanged.
- Reset mid-LOAD_MAT after 2 payload bytes, rx_valid back-to-back -> all outputs at reset values, size_o=8. Next SOF is parsed normally.
